// File: rtl/enc_uart_pkg.sv
// Shared types and defaults for the encoder-to-UART transmit path.
`timescale 1ns/1ps
package enc_uart_pkg;

  localparam int                BYTE_W              = 8;
  localparam int                FRAME_BYTES_DEFAULT = 8;
  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT   = 8'hA5;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_DONE
  } tx_state_t;

endpackage

// File: rtl/encoded_frame_tx_if.sv
// Valid/ready frame handshake between the encoder output buffer and the
// frame sequencer. The master owns data/valid and the slave owns ready.
`timescale 1ns/1ps
interface encoded_frame_tx_if
  import enc_uart_pkg::*;
#(
  parameter int FRAME_BYTES = FRAME_BYTES_DEFAULT
);

  logic [BYTE_W*FRAME_BYTES-1:0] frame_data;
  logic                          frame_valid;
  logic                          frame_ready;

  modport master (
    output frame_data,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_data,
    input  frame_valid,
    output frame_ready
  );

endinterface

// File: rtl/encoded_frame_tx.sv
// Streams one encoded frame to the UART transmitter, LSB byte first, with an
// optional leading sync byte. Each byte gets a one-cycle start pulse and is
// paced by the transmitter busy flag (rise, then fall). A stalled busy flag
// raises a sticky timeout error; flush ends the frame after the byte in flight.
`timescale 1ns/1ps
module encoded_frame_tx
  import enc_uart_pkg::*;
#(
  parameter int unsigned       FRAME_BYTES  = FRAME_BYTES_DEFAULT,
  parameter bit                SEND_SYNC    = 1'b1,
  parameter logic [BYTE_W-1:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int unsigned       BUSY_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  encoded_frame_tx_if.slave   frm,
  input  logic                flush,
  input  logic                tx_busy,
  output logic                tx_start,
  output logic [BYTE_W-1:0]   tx_data,
  output logic                frame_done,
  output logic                timeout_err
);

  localparam int FRAME_W = BYTE_W * FRAME_BYTES;
  // Signed byte index; -1 is the sync slot.
  localparam int IDX_W   = $clog2(FRAME_BYTES + 1) + 1;
  localparam int CNT_W   = $clog2(BUSY_TIMEOUT + 1);

  localparam logic signed [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  tx_state_t                state_q;
  logic                     frame_ready_q;
  logic                     tx_start_q;
  logic [BYTE_W-1:0]        tx_data_q;
  logic                     frame_done_q;
  logic                     timeout_err_q;
  logic                     flush_q;
  logic [CNT_W-1:0]         cnt_q;

  logic [FRAME_W-1:0]       shreg_q, shreg_d;
  logic signed [IDX_W-1:0]  idx_q, idx_d;

  logic                     accept;
  logic                     byte_end;
  logic                     last_byte;
  logic                     flush_seen;
  logic [BYTE_W-1:0]        issue_byte;

  // Next shift-register/index values and the byte to launch on the next start.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    shreg_d = shreg_q;
    idx_d   = idx_q;

    accept   = (state_q == ST_IDLE) && frm.frame_valid && frame_ready_q;
    byte_end = (state_q == ST_WAIT_LO) && !tx_busy;

    if (accept) begin
      shreg_d = frm.frame_data;
      idx_d   = SEND_SYNC ? '1 : '0;
    end else if (byte_end) begin
      // The sync slot does not consume payload, so only shift for real bytes.
      if (!idx_q[IDX_W-1]) begin
        shreg_d = shreg_q >> BYTE_W;
      end
      idx_d = idx_q + IDX_W'(1);
    end

    issue_byte = idx_d[IDX_W-1] ? SYNC_BYTE : shreg_d[BYTE_W-1:0];
    last_byte  = (idx_q == LAST_IDX);
    flush_seen = flush_q | flush;
  end

  // Frame payload and byte index; always reloaded on accept before use.
  always_ff @(posedge clk) begin
    // NOTE: pure datapath registers are deliberately left out of reset; the
    // state machine never reads them before an accept has loaded them.
    shreg_q <= shreg_d;
    idx_q   <= idx_d;
  end

  // Sequencer state machine with registered handshake and transmitter outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q       <= ST_IDLE;
      frame_ready_q <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      flush_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (state_q != ST_IDLE) begin
        flush_q <= flush_seen;
      end

      unique case (state_q)
        ST_IDLE: begin
          frame_ready_q <= 1'b1;
          if (accept) begin
            frame_ready_q <= 1'b0;
            timeout_err_q <= 1'b0;
            flush_q       <= 1'b0;
            state_q       <= ST_ISSUE;
            if (!tx_busy) begin
              tx_start_q <= 1'b1;
              tx_data_q  <= issue_byte;
            end
          end
        end

        // Either the start-pulse cycle, or waiting for a busy transmitter.
        ST_ISSUE: begin
          if (tx_start_q) begin
            state_q <= ST_WAIT_HI;
            cnt_q   <= CNT_W'(1);
          end else if (flush_seen) begin
            frame_done_q <= 1'b1;
            state_q      <= ST_DONE;
          end else if (!tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= issue_byte;
          end
        end

        // cnt_q counts cycles since the start pulse.
        ST_WAIT_HI: begin
          if (tx_busy) begin
            state_q <= ST_WAIT_LO;
          end else if (cnt_q >= CNT_LAST) begin
            timeout_err_q <= 1'b1;
            frame_done_q  <= 1'b1;
            state_q       <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_WAIT_LO: begin
          if (byte_end) begin
            if (last_byte || flush_seen) begin
              frame_done_q <= 1'b1;
              state_q      <= ST_DONE;
            end else begin
              tx_start_q <= 1'b1;
              tx_data_q  <= issue_byte;
              state_q    <= ST_ISSUE;
            end
          end
        end

        ST_DONE: begin
          frame_ready_q <= 1'b1;
          state_q       <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign frm.frame_ready = frame_ready_q;
  assign tx_start        = tx_start_q;
  assign tx_data         = tx_data_q;
  assign frame_done      = frame_done_q;
  assign timeout_err     = timeout_err_q;

endmodule
